// File: rtl/control_bird.sv
// control_bird: frame-paced control FSM for the bird datapath.
// Synchronises the go/jump keys, paces physics to a frame tick, sequences
// one velocity/position update per frame, hands each new position to the
// draw engine with a req/done handshake, and flags ground collision.
`timescale 1ns/1ps
module control_bird #(
  parameter int unsigned CLKS_PER_FRAME = 833333,
  parameter logic [7:0]  GROUND_Y       = 8'd110
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       jump_btn,
  input  logic [7:0] bird_y_in,
  input  logic       draw_done,
  output logic [1:0] cur_state,
  output logic       draw_req,
  output logic       restart,
  output logic       game_over,
  output logic       overrun
);

  localparam int unsigned      CNT_W    = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_FRAME - 1);

  // Command codes understood by the datapath
  localparam logic [1:0] CS_UPD_Y  = 2'd0;
  localparam logic [1:0] CS_UPD_VY = 2'd1;
  localparam logic [1:0] CS_HOLD   = 2'd2;
  localparam logic [1:0] CS_JUMP   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_JUMP,
    S_UPD_VY,
    S_UPD_Y,
    S_DRAW,
    S_OVER
  } state_t;

  state_t           state, state_nx;
  logic             go_s1, go_s2, go_d;
  logic             jump_s1, jump_s2, jump_d;
  logic             go_edge, jump_edge;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_active;
  logic             tick;
  logic             tick_pending;
  logic             jump_pending;
  logic [1:0]       cur_state_nx;
  logic             draw_req_nx;
  logic             restart_nx;
  logic             game_over_nx;

  // Two-stage synchronisers plus one edge-detect stage for both raw keys
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {go_s1, go_s2, go_d}       <= '0;
      {jump_s1, jump_s2, jump_d} <= '0;
    end else begin
      go_s1   <= go;
      go_s2   <= go_s1;
      go_d    <= go_s2;
      jump_s1 <= jump_btn;
      jump_s2 <= jump_s1;
      jump_d  <= jump_s2;
    end
  end

  assign go_edge   = go_s2 & ~go_d;
  assign jump_edge = jump_s2 & ~jump_d;

  assign frame_active = (state == S_WAIT)   || (state == S_JUMP) ||
                        (state == S_UPD_VY) || (state == S_UPD_Y) ||
                        (state == S_DRAW);
  assign tick = frame_active && (frame_cnt == CNT_LAST);

  // Free-running frame counter while a game is in progress
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      frame_cnt <= '0;
    else if (!frame_active || tick)
      frame_cnt <= '0;
    else
      frame_cnt <= frame_cnt + CNT_W'(1);
  end

  // Remember a tick that landed while busy; several misses collapse into one
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      tick_pending <= 1'b0;
    else if (!frame_active)
      tick_pending <= 1'b0;
    else if (state == S_WAIT) begin
      if (state_nx != S_WAIT)
        tick_pending <= 1'b0;
    end else if (tick)
      tick_pending <= 1'b1;
  end

  // Sticky overrun flag, cleared only when leaving game-over
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      overrun <= 1'b0;
    else if ((state == S_OVER) && go_edge)
      overrun <= 1'b0;
    else if (tick && (state != S_WAIT))
      overrun <= 1'b1;
  end

  // Latched jump request; a new edge on the consume cycle wins over the clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      jump_pending <= 1'b0;
    else if (state == S_IDLE)
      jump_pending <= 1'b0;
    else if (jump_edge && frame_active)
      jump_pending <= 1'b1;
    else if ((state == S_WAIT) && (state_nx == S_JUMP))
      jump_pending <= 1'b0;
  end

  // Next-state logic and output decode from the next state
  always_comb begin
    state_nx     = state;
    restart_nx   = 1'b0;
    cur_state_nx = CS_HOLD;
    draw_req_nx  = 1'b0;
    game_over_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (go_edge) begin
          state_nx   = S_WAIT;
          restart_nx = 1'b1;
        end
      end
      S_WAIT: begin
        if (tick || tick_pending)
          state_nx = jump_pending ? S_JUMP : S_UPD_VY;
      end
      S_JUMP:   state_nx = S_UPD_Y;
      S_UPD_VY: state_nx = S_UPD_Y;
      S_UPD_Y:  state_nx = S_DRAW;
      S_DRAW: begin
        if (draw_done)
          state_nx = (bird_y_in >= GROUND_Y) ? S_OVER : S_WAIT;
      end
      S_OVER: begin
        if (go_edge)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_JUMP:   cur_state_nx = CS_JUMP;
      S_UPD_VY: cur_state_nx = CS_UPD_VY;
      S_UPD_Y:  cur_state_nx = CS_UPD_Y;
      default:  cur_state_nx = CS_HOLD;
    endcase
    draw_req_nx  = (state_nx == S_DRAW);
    game_over_nx = (state_nx == S_OVER);
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cur_state <= CS_HOLD;
      draw_req  <= 1'b0;
      restart   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_state <= cur_state_nx;
      draw_req  <= draw_req_nx;
      restart   <= restart_nx;
      game_over <= game_over_nx;
    end
  end

endmodule

// File: tb/tb_control_bird.sv
// Testbench for control_bird: randomized key/draw-engine stimulus, a
// timestamp-based reference model feeding a scoreboard, and a monitor that
// compares every cycle in which the DUT presents activity.
`timescale 1ns/1ps
module tb_control_bird;

  localparam int         CPF = 16;
  localparam logic [7:0] GY  = 8'd110;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       jump_btn = 1'b0;
  logic [7:0] bird_y_in = 8'd0;
  logic       draw_done = 1'b0;
  logic [1:0] cur_state;
  logic       draw_req;
  logic       restart;
  logic       game_over;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int ev_seen = 0;
  int cyc = 0;

  typedef struct packed {
    logic [1:0] code;
    logic       req;
    logic       rst;
    logic       gov;
    logic       ovr;
  } snap_t;

  typedef struct {
    int    at;
    snap_t s;
  } ev_t;

  typedef enum int {M_IDLE, M_PLAY, M_OVER} mode_t;

  localparam snap_t RESET_SNAP = '{code: 2'd2, req: 1'b0, rst: 1'b0, gov: 1'b0, ovr: 1'b0};

  ev_t sb[$];

  // stimulus controls shared with the draw engine and key driver
  bit jrand_en = 0;
  bit grand_en = 0;
  int jcnt = 0;
  int gcnt = 0;
  int y_mode = 0;
  int stall_pct = 15;
  bit force_stall = 0;

  control_bird #(.CLKS_PER_FRAME(CPF), .GROUND_Y(GY)) dut (
    .clk(clk), .resetn(resetn), .go(go), .jump_btn(jump_btn),
    .bird_y_in(bird_y_in), .draw_done(draw_done), .cur_state(cur_state),
    .draw_req(draw_req), .restart(restart), .game_over(game_over), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference model: frames start on ticks at s0+15+16k or right after a busy
  // period that swallowed a tick; each frame is code (3|1) then 0 then a draw
  // that lasts until draw_done is sampled.
  initial begin : model
    bit          gh[4];
    bit          jh[4];
    mode_t       mode;
    int          s0, draw_from, c;
    bit          busy, missed, ovr, rst_next, go_e, jmp_e, tick, jump;
    int          jq[$];
    logic [1:0]  code_at[int];
    snap_t       prev, e;
    ev_t         ev;
    mode = M_IDLE; s0 = 0; draw_from = 0; busy = 0; missed = 0; ovr = 0;
    prev = RESET_SNAP;
    for (int i = 0; i < 4; i++) begin gh[i] = 0; jh[i] = 0; end
    forever begin
      @(posedge clk);
      c = cyc;
      if (!resetn) begin
        mode = M_IDLE; busy = 0; missed = 0; ovr = 0;
        for (int i = 0; i < 4; i++) begin gh[i] = 0; jh[i] = 0; end
        jq.delete();
        code_at.delete();
        sb.delete();
        prev = RESET_SNAP;
        cyc = c + 1;
      end else begin
        for (int i = 3; i > 0; i--) begin gh[i] = gh[i-1]; jh[i] = jh[i-1]; end
        gh[0] = go;
        jh[0] = jump_btn;
        go_e  = gh[2] && !gh[3];
        jmp_e = jh[2] && !jh[3];
        rst_next = 0;
        case (mode)
          M_IDLE: begin
            if (go_e) begin
              mode = M_PLAY; s0 = c + 1; busy = 0; missed = 0;
              jq.delete(); rst_next = 1;
            end
          end
          M_PLAY: begin
            tick = (c >= s0) && (((c - s0) % CPF) == CPF - 1);
            if (jmp_e) jq.push_back(c);
            if (!busy) begin
              if (tick || missed) begin
                jump = 0;
                while (jq.size() > 0 && jq[0] < c) begin
                  jump = 1;
                  void'(jq.pop_front());
                end
                code_at[c+1] = jump ? 2'd3 : 2'd1;
                code_at[c+2] = 2'd0;
                draw_from = c + 3;
                busy = 1;
                missed = 0;
              end
            end else begin
              if (tick) begin missed = 1; ovr = 1; end
              if (c >= draw_from && draw_done) begin
                busy = 0;
                if (bird_y_in >= GY) mode = M_OVER;
              end
            end
          end
          default: begin
            if (go_e) begin mode = M_IDLE; ovr = 0; end
          end
        endcase
        cyc = c + 1;
        e.code = code_at.exists(cyc) ? code_at[cyc] : 2'd2;
        if (code_at.exists(cyc)) code_at.delete(cyc);
        e.req = (mode == M_PLAY) && busy && (cyc >= draw_from);
        e.rst = rst_next;
        e.gov = (mode == M_OVER);
        e.ovr = ovr;
        if (e.code != 2'd2 || e != prev) begin
          ev.at = cyc;
          ev.s  = e;
          sb.push_back(ev);
        end
        prev = e;
      end
    end
  end

  // Monitor: whenever the DUT shows an update code or any output changes,
  // pop the expected record for this cycle and compare.
  initial begin : monitor
    snap_t dprev, d;
    ev_t   x;
    dprev = RESET_SNAP;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        dprev = RESET_SNAP;
      end else begin
        d = '{code: cur_state, req: draw_req, rst: restart, gov: game_over, ovr: overrun};
        while (sb.size() > 0 && sb[0].at < cyc) begin
          x = sb.pop_front();
          total++; bad++;
          $display("FAIL missed_event expected@%0d code=%0d req=%0b rst=%0b over=%0b ovr=%0b got nothing",
                   x.at, x.s.code, x.s.req, x.s.rst, x.s.gov, x.s.ovr);
        end
        if (d.code != 2'd2 || d != dprev) begin
          ev_seen++;
          total++;
          if (sb.size() == 0 || sb[0].at != cyc) begin
            bad++;
            $display("FAIL unexpected_event @%0d got code=%0d req=%0b rst=%0b over=%0b ovr=%0b expected no change",
                     cyc, d.code, d.req, d.rst, d.gov, d.ovr);
          end else begin
            x = sb.pop_front();
            if (x.s != d) begin
              bad++;
              $display("FAIL event @%0d got code=%0d req=%0b rst=%0b over=%0b ovr=%0b expected code=%0d req=%0b rst=%0b over=%0b ovr=%0b",
                       cyc, d.code, d.req, d.rst, d.gov, d.ovr,
                       x.s.code, x.s.req, x.s.rst, x.s.gov, x.s.ovr);
            end
          end
        end
        dprev = d;
      end
    end
  end

  function automatic logic [7:0] pick_y(input int mode);
    logic [7:0] y;
    if (mode == 0) begin
      if ($urandom_range(0, 3) == 0) y = 8'd109;
      else y = 8'($urandom_range(0, 108));
    end else begin
      case ($urandom_range(0, 2))
        0:       y = 8'd110;
        1:       y = 8'd115;
        default: y = 8'd255;
      endcase
    end
    return y;
  endfunction

  // Draw engine model: answers draw_req after 4 cycles (or a 40-cycle stall),
  // and occasionally pulses draw_done while no draw is outstanding.
  initial begin : draw_engine
    int waited;
    int delay;
    bit sent;
    waited = 0; delay = 4; sent = 0;
    forever begin
      @(posedge clk); #1;
      draw_done = 1'b0;
      bird_y_in = 8'($urandom_range(0, 255));
      if (draw_req && !sent) begin
        if (waited == 0) begin
          delay = (force_stall || ($urandom_range(0, 99) < stall_pct)) ? 40 : 4;
          force_stall = 0;
        end
        waited++;
        if (waited >= delay) begin
          draw_done = 1'b1;
          bird_y_in = pick_y(y_mode);
          sent = 1;
        end
      end else if (!draw_req) begin
        waited = 0;
        sent = 0;
        if ($urandom_range(0, 15) == 0) draw_done = 1'b1;
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (jrand_en) begin
        if (jcnt > 0) jcnt--;
        else if (jump_btn) jump_btn = 1'b0;
        else if ($urandom_range(0, 19) == 0) begin
          jump_btn = 1'b1;
          jcnt = $urandom_range(0, 5);
        end
      end
      if (grand_en) begin
        if (gcnt > 0) gcnt--;
        else if (go) go = 1'b0;
        else if ($urandom_range(0, 149) == 0) begin
          go = 1'b1;
          gcnt = $urandom_range(0, 3);
        end
      end
    end
  endtask

  task automatic press_go();
    go = 1'b1;
    cycles(3);
    go = 1'b0;
    cycles(2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit seen;
    int stale;
    resetn = 1'b0;
    cycles(3);
    check("reset_cur_state", cur_state, 2);
    check("reset_draw_req", draw_req, 0);
    check("reset_restart", restart, 0);
    check("reset_game_over", game_over, 0);
    check("reset_overrun", overrun, 0);
    @(negedge clk); #2 resetn = 1'b1;
    cycles(2);

    // normal play: random jumps, ignored go presses, stalls
    press_go();
    force_stall = 1;
    jrand_en = 1;
    grand_en = 1;
    cycles(700);
    grand_en = 0;
    go = 1'b0;
    jrand_en = 0;
    jump_btn = 1'b1;
    cycles(100);
    jump_btn = 1'b0;
    jrand_en = 1;
    cycles(400);
    check("overrun_after_stall", overrun, 1);

    // ground collision
    y_mode = 1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycles(1);
      if (game_over) seen = 1;
    end
    check("game_over_reached", seen, 1);
    check("over_cur_state", cur_state, 2);
    check("over_draw_req", draw_req, 0);
    y_mode = 0;
    jrand_en = 0;
    jump_btn = 1'b0;
    cycles(5);
    press_go();
    cycles(5);
    check("idle_game_over", game_over, 0);
    check("idle_overrun", overrun, 0);
    press_go();
    jrand_en = 1;
    cycles(300);

    // asynchronous reset in the middle of a draw
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (draw_req) seen = 1;
      else cycles(1);
    end
    check("draw_req_before_reset", seen, 1);
    cycles(1);
    #1 resetn = 1'b0;
    #1;
    check("async_reset_draw_req", draw_req, 0);
    check("async_reset_cur_state", cur_state, 2);
    jrand_en = 0;
    jump_btn = 1'b0;
    cycles(2);
    @(negedge clk); #2 resetn = 1'b1;
    cycles(20);
    check("post_reset_cur_state", cur_state, 2);
    check("post_reset_draw_req", draw_req, 0);

    press_go();
    jrand_en = 1;
    cycles(400);
    jrand_en = 0;
    jump_btn = 1'b0;
    cycles(60);
    @(negedge clk); #1;
    stale = 0;
    foreach (sb[i]) if (sb[i].at <= cyc) stale++;
    check("scoreboard_drained", stale, 0);
    check("monitor_activity", (ev_seen >= 100) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
